// File: rtl/vga_timing_generator.sv
// vga_timing_generator
//
// Pixel-rate timing for the VGA path, running entirely on the board clock.
// A divider produces a one-clock pixel enable every CLK_DIV clocks; on each
// enable the (h, v) position advances. All outputs are registered decodes of
// the new position, so they change only on pixel boundaries.
//
// Line layout: sync, back porch, active, front porch (frame layout is the same).
//
// Ports:
//   clock        board clock
//   reset_n      asynchronous active-low reset
//   pix_en       one-clock strobe in the first clock of each pixel period
//   h_sync       horizontal sync, active-low
//   v_sync       vertical sync, active-low
//   blank_n      high inside the visible area
//   sync_n       DAC composite sync, tied low
//   pixel_x      visible column, 0 outside the visible area
//   pixel_y      visible row, 0 outside the visible area
//   line_start   high for the pixel period at h=0 (not for the post-reset line)
//   frame_start  high for the pixel period at (0,0) reached by wrapping
//   frame_count  frames started since reset (mod 256)
//
// Optional feature: define VGA_FRAME_COUNTER_EN to build the frame counter;
// otherwise frame_count is tied to 0.

module vga_timing_generator #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic       pix_en,
    output logic       h_sync,
    output logic       v_sync,
    output logic       blank_n,
    output logic       sync_n,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic             vis_d;

    logic       pix_en_q, h_sync_q, v_sync_q, blank_n_q;
    logic [9:0] pixel_x_q, pixel_y_q;
    logic       line_start_q, frame_start_q, frame_start_d;

    // The position advances on the same edge that raises pix_en, so pix_en
    // marks the first clock of every new pixel period.
    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
        vis_d = (h_d >= H_VIS_START) && (h_d < H_VIS_END) &&
                (v_d >= V_VIS_START) && (v_d < V_VIS_END);
        // h_d is only 0 via a wrap, so the post-reset line never pulses.
        frame_start_d = (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            h_sync_q      <= 1'b0;
            v_sync_q      <= 1'b0;
            blank_n_q     <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= tick;
            if (tick) begin
                h_q           <= h_d;
                v_q           <= v_d;
                h_sync_q      <= (h_d >= H_SYNC_END);
                v_sync_q      <= (v_d >= V_SYNC_END);
                blank_n_q     <= vis_d;
                pixel_x_q     <= vis_d ? h_d - H_VIS_START : '0;
                pixel_y_q     <= vis_d ? v_d - V_VIS_START : '0;
                line_start_q  <= (h_d == '0);
                frame_start_q <= frame_start_d;
            end
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] frame_count_q;

    // Counts on the edge that raises frame_start, so the new value is
    // visible alongside the pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
        end else if (tick && frame_start_d) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif

    assign pix_en      = pix_en_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign blank_n     = blank_n_q;
    assign sync_n      = 1'b0;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Upstream timing stage for the VGA video path. It derives a pixel-rate enable from the 50 MHz board clock and runs the horizontal and vertical counters. It produces the registered sync, blank and pixel-coordinate signals that the colour/renderer stage consumes. It replaces the separate clock divider and horizontal/vertical counter instances with one synchronous, enable-based block, so the design has no derived clock.

Parameters:
CLK_DIV, 2, board clocks per pixel (50 MHz / 2 = 25 MHz pixel rate); must be >= 1
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines

Ports:
clock  input  1  board clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
pix_en  output  1  one-clock strobe, once every CLK_DIV clocks; marks pixel boundaries
h_sync  output  1  horizontal sync, active-low
v_sync  output  1  vertical sync, active-low
blank_n  output  1  high inside the visible area
sync_n  output  1  DAC composite sync, constant 0
pixel_x  output  10  visible column 0..H_ACTIVE-1; 0 outside the visible area
pixel_y  output  10  visible row 0..V_ACTIVE-1; 0 outside the visible area
line_start  output  1  high for the pixel period at h=0
frame_start  output  1  high for the pixel period at (h,v)=(0,0) after a wrap
frame_count  output  8  frame counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain, clock. reset_n is asynchronous active-low; it clears every register immediately.
- Line and frame totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP = 800. V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP = 525.
- Position P = (h,v): h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
- Segment order within each line/frame: sync, back porch, active, front porch. Sync starts at h=0 / v=0.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en is a registered pulse that is high on the clock where div == CLK_DIV-1. pix_en is 0 in reset. The first pix_en comes CLK_DIV clocks after reset release.
- Advancing P:
  - On each pix_en clock edge, h increments.
  - When h = H_TOTAL-1, h wraps to 0 and v increments.
  - When v = V_TOTAL-1 and h wraps, v also wraps to 0.
- All outputs are registered decodes of P and change only on pix_en edges.
- Reset values: P=(0,0); h_sync=0, v_sync=0, blank_n=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0, frame_count=0, pix_en=0. There is no line_start/frame_start pulse for the reset period.
- h_sync is 0 while h < H_SYNC.
- v_sync is 0 while v < V_SYNC.
- Visible area: h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), i.e. 144..783, and v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE), i.e. 35..514.
- blank_n is 1 only inside the visible area.
- pixel_x = h-144 and pixel_y = v-35 inside the visible area; both are 0 elsewhere.
- line_start is 1 for the pixel period at h=0 for every line after the first post-reset line.
- frame_start is 1 for the pixel period at (0,0) reached by wrapping.
- Counter arithmetic: unsigned, 10 bits for h and v, with an explicit compare-and-wrap. Counters never take values >= their total.
- Reset mid-operation: reset_n low at any point returns all state to the reset values within the same cycle. Counting restarts from P=(0,0) after release.

Optional Feature:
Macro VGA_FRAME_COUNTER_EN.
- Defined: frame_count is an 8-bit register that increments by 1 on each frame_start pulse, wraps 255->0, and clears on reset.
- Not defined: frame_count is tied to 0 and no register is built.

Test Plan:
- Reset release, count clocks -> pix_en high every 2nd clock; first pix_en 2 clocks after release.
- One line -> h_sync low for 192 clocks (96 pixels); line period 1600 clocks; line_start once per line.
- First visible pixel -> at h=144, v=35: blank_n=1, pixel_x=0, pixel_y=0. At h=783: pixel_x=639. At h=784: blank_n=0, pixel_x=0.
- Full frame -> v_sync low for 2 lines (3200 clocks); frame period 840000 clocks; frame_start once; last visible pixel has pixel_y=479.
- reset_n pulsed low mid-line at h=400, v=200 -> outputs return to reset values immediately; after release, h_sync low again for 192 clocks from P=(0,0).
- With VGA_FRAME_COUNTER_EN, run 257 frames -> frame_count reads 1 (wrapped through 255->0). Without the macro -> frame_count stays 0.
